rsa_decoder: RTL and testbench
==============================

# rsa_decoder

RSA decryption core computing m = c^d mod n for the 12-bit toy key pair used by the encryption path, so that rsa_decoder(rsa encryption output) returns the original plaintext. It contains a constant-time left-to-right square-and-multiply exponentiation FSM driving one radix-2^logr Montgomery multiplier. It sits on the receive side of the cipher datapath, behind the same start/done handshake as the encryption side.

## Interface
- n, 12'd3551: modulus (53·67)
- n_bit, 12: operand width
- logr, 3: Montgomery digit width; NDIG = ceil(n_bit/logr) = 4
- p, 3'd1: −n⁻¹ mod 2^logr
- Rmodn, 12'd545: R mod n, R = 2^(NDIG·logr) = 2^12
- R2modn, 12'd2292: R² mod n
- d, 12'd1373: private exponent (e·d ≡ 1 mod φ(n) = 3432, e = 5)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only while busy = 0
- data_in  in  n_bit  ciphertext c, sampled with start
- data_out  out  n_bit  plaintext m; held until next done
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive
- err  out  1  valid with done; 1 = c ≥ n was rejected

## Operation
- Reset (rst_n = 0 at an edge): state IDLE, data_out = 0, done = 0, busy = 0, err = 0, multiplier aborted. Applies mid-operation; the in-flight result is discarded and no done is produced.
- States: IDLE → CHECK → TOMONT → SQR → MUL → (SQR … ) → FROMMONT → FIN → IDLE.
- IDLE: on start = 1, latch c = data_in; go to CHECK.
- CHECK: if c ≥ n: data_out = 0, err = 1, done = 1, return to IDLE. Otherwise err = 0; go to TOMONT.
- TOMONT: x̄ = MM(c, R2modn); acc = Rmodn (Montgomery 1); bit index i = n_bit−1.
- For i = n_bit−1 down to 0: SQR acc = MM(acc, acc); MUL t = MM(acc, x̄), acc = t if d[i] = 1, else acc unchanged. MUL is always executed (constant time; latency independent of d and c).
- FROMMONT: acc = MM(acc, 1).
- FIN: data_out = acc, done = 1, return to IDLE.
- MM(a,b) = a·b·R⁻¹ mod n, a,b < n. Result is always fully reduced (< n) after the conditional final subtraction. Internal accumulator width is n_bit+logr+1 bits; no truncation before the final subtraction.
- start while busy = 1 is ignored (not queued). start in the same cycle as done/FIN is ignored; it is accepted from IDLE on the next cycle.

## Timing
- Each MM operation occupies exactly NDIG+2 = 6 cycles: 1 load, NDIG digit iterations, 1 final subtract.
- MM count per decryption = 2·n_bit + 2 = 26.
- start accepted at edge k → done high in cycle k + 1 + 26·6 + 1 = k + 158 (defaults); generally k + (2·n_bit+2)(NDIG+2) + 2.
- Rejected input: done and err high in cycle k+1 (busy high during that single cycle).
- data_out and err update in the same cycle as done and hold until the next done or reset.
- Back-to-back: minimum start-to-start spacing = latency + 1 cycle.

## Structure
- Shared package: key constants n, n_bit, logr, p, Rmodn, R2modn, e, d; NDIG; FSM state enum.
- Sub-module mont_mul (params n, n_bit, logr, p; ports clk, rst_n, start, a, b, z, done), fixed 6-cycle latency, single instance reused by the FSM. The same sub-module is shared with the encryption path.

## Test plan
- c = 32 (= 2^5 mod 3551) → data_out = 2, err = 0, done exactly 158 cycles after start.
- c = 492 (= 100^5 mod 3551) → 100; c = 3550 → 3550; c = 0 → 0; c = 1 → 1.
- Loopback: all m in 0..3550 through the encryption path then rsa_decoder → data_out = m every time; latency constant 158 for every input.
- c = 3551 and c = 4095 → done at k+1, err = 1, data_out = 0; a following valid c = 32 gives 2, err = 0.
- start pulsed again at k+50 with c = 492 during a c = 32 job → single done at k+158 with 2; no second done.
- rst_n low for one cycle at k+80 → busy = 0, data_out = 0, no done; new start with c = 492 → 100 after 158 cycles.

Source files
------------

// File: rtl/rsa_decoder_pkg.sv
// Key material and shared types for the 12-bit toy RSA decryption core.
// Both the decoder FSM and the Montgomery multiplier draw their constants from here.
package rsa_decoder_pkg;

  localparam int n_bit = 12;
  localparam int logr  = 3;
  localparam int ndig  = (n_bit + logr - 1) / logr;

  // Modulus 53*67; R = 2^(ndig*logr) = 4096
  localparam logic [n_bit-1:0] n      = 12'd3551;
  localparam logic [logr-1:0]  p      = 3'd1;
  localparam logic [n_bit-1:0] rmodn  = 12'd545;
  localparam logic [n_bit-1:0] r2modn = 12'd2292;
  localparam logic [n_bit-1:0] e      = 12'd5;
  localparam logic [n_bit-1:0] d      = 12'd1373;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_TOMONT,
    ST_SQR,
    ST_MUL,
    ST_FROMMONT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/rsa_decoder_mont.sv
// Radix-2^logr Montgomery multiplier: z = a*b*R^-1 mod n in ndig+2 cycles.
// Reused by the encryption path, so it keeps its own parameters and types.
module mont_mul #(
  parameter int               n_bit = 12,
  parameter int               logr  = 3,
  parameter logic [n_bit-1:0] n     = 12'd3551,
  parameter logic [logr-1:0]  p     = 3'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [n_bit-1:0] a,
  input  logic [n_bit-1:0] b,
  output logic [n_bit-1:0] z,
  output logic             done
);

  localparam int ndig  = (n_bit + logr - 1) / logr;
  localparam int a_w   = ndig * logr;
  localparam int acc_w = n_bit + logr + 1;
  localparam int cnt_w = $clog2(ndig + 1);

  typedef enum logic [1:0] {MM_IDLE, MM_RUN, MM_SUB} mm_phase_t;

  mm_phase_t        phase, phase_next;
  logic [a_w-1:0]   a_q;
  logic [n_bit-1:0] b_q;
  logic [acc_w-1:0] acc_q;
  logic [cnt_w-1:0] cnt_q;

  logic [logr-1:0]  digit, q;
  logic [acc_w-1:0] sum1, sum2, acc_next;
  logic [n_bit-1:0] diff;

  // acc stays below 2n between digits, so sum2 < 16n fits in acc_w bits
  always_comb begin
    digit    = a_q[logr-1:0];
    sum1     = acc_q + acc_w'(digit) * acc_w'(b_q);
    q        = sum1[logr-1:0] * p;
    sum2     = sum1 + acc_w'(q) * acc_w'(n);
    acc_next = sum2 >> logr;
    diff     = acc_q[n_bit-1:0] - n;
  end

  always_comb begin
    phase_next = phase;
    if (start) begin
      phase_next = MM_RUN;
    end else begin
      case (phase)
        MM_RUN:  if (cnt_q == cnt_w'(ndig - 1)) phase_next = MM_SUB;
        MM_SUB:  phase_next = MM_IDLE;
        default: phase_next = phase;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= MM_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      z     <= '0;
      done  <= 1'b0;
    end else begin
      phase <= phase_next;
      done  <= 1'b0;
      if (start) begin
        a_q   <= a_w'(a);
        b_q   <= b;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (phase == MM_RUN) begin
        acc_q <= acc_next;
        a_q   <= a_q >> logr;
        cnt_q <= cnt_q + cnt_w'(1);
      end else if (phase == MM_SUB) begin
        z    <= (acc_q >= acc_w'(n)) ? diff : acc_q[n_bit-1:0];
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_decoder.sv
// RSA decryption m = c^d mod n via constant-time left-to-right square-and-multiply
// over a single shared Montgomery multiplier.
module rsa_decoder
  import rsa_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [n_bit-1:0] data_in,
  output logic [n_bit-1:0] data_out,
  output logic             done,
  output logic             busy,
  output logic             err,
  output state_t           state_dbg
);

  // Handshake: start is taken only when busy = 0 (data_in sampled with it);
  // busy stays high through the one-cycle done pulse, which carries data_out/err.
  state_t           state, state_next;
  logic [n_bit-1:0] c_q, xbar_q, acc_q, acc_mul;
  logic [3:0]       idx_q;
  logic             accept, reject;

  logic             mm_start, mm_done;
  logic [n_bit-1:0] mm_a, mm_b, mm_z;

  mont_mul #(
    .n_bit(n_bit),
    .logr (logr),
    .n    (n),
    .p    (p)
  ) u_mm (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mm_start),
    .a    (mm_a),
    .b    (mm_b),
    .z    (mm_z),
    .done (mm_done)
  );

  assign state_dbg = state;
  assign accept    = (state == ST_IDLE) && start && !busy;
  assign reject    = (c_q >= n);
  // MUL always runs; the exponent bit only selects which value is kept
  assign acc_mul   = d[idx_q] ? mm_z : acc_q;

  always_comb begin
    state_next = state;
    mm_start   = 1'b0;
    mm_a       = '0;
    mm_b       = '0;
    case (state)
      ST_IDLE: if (accept) state_next = ST_CHECK;
      ST_CHECK: begin
        if (reject) begin
          state_next = ST_IDLE;
        end else begin
          mm_start   = 1'b1;
          mm_a       = c_q;
          mm_b       = r2modn;
          state_next = ST_TOMONT;
        end
      end
      ST_TOMONT: if (mm_done) begin
        mm_start   = 1'b1;
        mm_a       = rmodn;
        mm_b       = rmodn;
        state_next = ST_SQR;
      end
      ST_SQR: if (mm_done) begin
        mm_start   = 1'b1;
        mm_a       = mm_z;
        mm_b       = xbar_q;
        state_next = ST_MUL;
      end
      ST_MUL: if (mm_done) begin
        mm_start = 1'b1;
        mm_a     = acc_mul;
        if (idx_q == 4'd0) begin
          mm_b       = n_bit'(1);
          state_next = ST_FROMMONT;
        end else begin
          mm_b       = acc_mul;
          state_next = ST_SQR;
        end
      end
      ST_FROMMONT: if (mm_done) state_next = ST_FIN;
      ST_FIN:      state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q      <= '0;
      xbar_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
      case (state)
        ST_IDLE: if (accept) c_q <= data_in;
        ST_CHECK: if (reject) begin
          data_out <= '0;
          err      <= 1'b1;
          done     <= 1'b1;
        end
        ST_TOMONT: if (mm_done) begin
          xbar_q <= mm_z;
          acc_q  <= rmodn;
          idx_q  <= 4'(n_bit - 1);
        end
        ST_SQR: if (mm_done) acc_q <= mm_z;
        ST_MUL: if (mm_done) begin
          acc_q <= acc_mul;
          if (idx_q != 4'd0) idx_q <= idx_q - 4'd1;
        end
        ST_FROMMONT: if (mm_done) acc_q <= mm_z;
        ST_FIN: begin
          data_out <= acc_q;
          err      <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decoder.sv
// Directed bench for rsa_decoder: known ciphertexts, rejects, ignored starts,
// mid-job reset and a short encrypt/decrypt loopback.
module tb_rsa_decoder;
  import rsa_decoder_pkg::*;

  localparam int lat = 158;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] data_out;
  logic        done, busy, err;
  state_t      state_dbg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  rsa_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .busy     (busy),
    .err      (err),
    .state_dbg(state_dbg)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] encrypt(input int m);
    longint r = 1;
    for (int i = 0; i < 5; i++) r = (r * m) % 3551;
    return 12'(r);
  endfunction

  // Counts edges after the accepting edge until done is seen; optionally pokes
  // a second start or a one-cycle reset at a given edge offset.
  task automatic wait_done(input int budget, input int poke_at, input logic [11:0] poke_c,
                           input int rst_at, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == poke_at - 1) begin
        start   = 1'b1;
        data_in = poke_c;
      end else if (cyc == poke_at) begin
        start = 1'b0;
      end
      if (cyc == rst_at - 1) begin
        rst_n = 1'b0;
      end else if (cyc == rst_at) begin
        rst_n = 1'b1;
        check_val("rst_busy", busy, 0);
        check_val("rst_data_out", data_out, 0);
        check_val("rst_state", state_dbg, ST_IDLE);
        exp_q.delete();
      end
      if (done) seen = 1'b1;
    end
  endtask

  task automatic issue(input logic [11:0] c);
    int guard = 0;
    while (busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    start   = 1'b1;
    data_in = c;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("accept_busy", busy, 1);
  endtask

  task automatic run_job(input string tag, input logic [11:0] c, input logic [11:0] exp_m,
                         input logic exp_err, input int exp_lat,
                         input int poke_at, input logic [11:0] poke_c);
    int cyc;
    bit seen;
    int extra;
    issue(c);
    exp_q.push_back(exp_m);
    wait_done(400, poke_at, poke_c, -10, cyc, seen);
    check_val({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check_val({tag, "_latency"}, cyc, exp_lat);
      check_val({tag, "_err"}, err, exp_err);
      check_val({tag, "_busy_at_done"}, busy, 1);
      check_val({tag, "_queue"}, exp_q.size(), 1);
      if (exp_q.size() > 0) check_val({tag, "_data_out"}, data_out, exp_q.pop_front());
      extra = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) extra++;
      end
      check_val({tag, "_single_done"}, extra, 0);
      check_val({tag, "_busy_after"}, busy, 0);
      check_val({tag, "_hold"}, data_out, exp_m);
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    int m;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("reset_data_out", data_out, 0);
    check_val("reset_done", done, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_err", err, 0);
    check_val("reset_state", state_dbg, ST_IDLE);

    run_job("c32", 12'd32, 12'd2, 1'b0, lat, -10, '0);
    run_job("c492", 12'd492, 12'd100, 1'b0, lat, -10, '0);
    run_job("c3550", 12'd3550, 12'd3550, 1'b0, lat, -10, '0);
    run_job("c0", 12'd0, 12'd0, 1'b0, lat, -10, '0);
    run_job("c1", 12'd1, 12'd1, 1'b0, lat, -10, '0);

    run_job("rej3551", 12'd3551, 12'd0, 1'b1, 1, -10, '0);
    run_job("rej4095", 12'd4095, 12'd0, 1'b1, 1, -10, '0);
    run_job("after_rej", 12'd32, 12'd2, 1'b0, lat, -10, '0);

    // second start while busy must be dropped
    run_job("busy_start", 12'd32, 12'd2, 1'b0, lat, 50, 12'd492);

    // one-cycle reset mid-job: no done, then a fresh job works
    issue(12'd32);
    exp_q.push_back(12'd2);
    wait_done(200, -10, '0, 80, cyc, seen);
    check_val("rst_no_done", seen, 0);
    check_val("rst_queue_cleared", exp_q.size(), 0);
    run_job("post_rst", 12'd492, 12'd100, 1'b0, lat, -10, '0);

    for (int k = 0; k < 16; k++) begin
      m = (k == 0) ? 3550 : $urandom_range(0, 3550);
      run_job("loopback", encrypt(m), 12'(m), 1'b0, lat, -10, '0);
    end

    check_val("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
